// File: rtl/hazard_scoreboard.sv
// Register-read hazard scoreboard: per-register countdown of cycles until a
// pending result can be forwarded, with flush and a stall watchdog.
module hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 3,
  parameter int STALL_W   = 8,
  parameter int MAX_STALL = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_AW-1:0]    rs1_rr,
  input  logic [REG_AW-1:0]    rs2_rr,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [REG_AW-1:0]    issue_rd,
  input  logic [LAT_W-1:0]     issue_lat,
  input  logic                 flush,
  output logic                 h_lock,
  output logic [2**REG_AW-1:0] busy_vec,
  output logic                 stall_timeout
);

  localparam int NREG = 2**REG_AW;

  logic [LAT_W-1:0]   cnt_q [NREG];
  logic [LAT_W-1:0]   cnt_d [NREG];
  logic [STALL_W-1:0] stall_run_q;
  logic [STALL_W-1:0] stall_run_d;
  logic               stall_timeout_q;
  logic               stall_timeout_d;
  logic               hit1;
  logic               hit2;
  logic               issue;

  function automatic logic [LAT_W-1:0] dec(
    input logic [LAT_W-1:0] x
  );
    return (x == '0) ? '0 : x - LAT_W'(1);
  endfunction

  always_comb begin
    hit1   = use_rs1 && (rs1_rr != '0)
          && (cnt_q[rs1_rr] != '0);
    hit2   = use_rs2 && (rs2_rr != '0)
          && (cnt_q[rs2_rr] != '0);
    h_lock = hit1 || hit2;
    issue  = issue_valid && !h_lock && !flush;
  end

  // cnt holds remaining stall cycles: a latency-L producer leaves L-1.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = dec(cnt_q[r]);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (issue && issue_we && r != 0
                   && issue_rd == REG_AW'(r)) begin
        if (issue_lat > cnt_q[r])
          cnt_d[r] = dec(issue_lat);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy_vec[r] = (cnt_q[r] != '0);
  end

  always_comb begin
    stall_run_d     = '0;
    stall_timeout_d = stall_timeout_q;
    if (!flush && h_lock) begin
      if (stall_run_q != '1)
        stall_run_d = stall_run_q + STALL_W'(1);
      else
        stall_run_d = stall_run_q;
      if (stall_run_q >= STALL_W'(MAX_STALL - 1))
        stall_timeout_d = 1'b1;
    end else if (flush && h_lock) begin
      if (stall_run_q >= STALL_W'(MAX_STALL - 1))
        stall_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      stall_run_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      stall_run_q     <= stall_run_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign stall_timeout = stall_timeout_q;

endmodule
